// File: rtl/count_monitor_pkg.sv
// +------------------------------------------------------------------+
// | count_monitor_pkg : FSM state codes and step classification      |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package count_monitor_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] TRACK   = 2'd1;
  localparam logic [1:0] STALLED = 2'd2;

  typedef enum logic [1:0] {
    STEP = 2'd0,
    WRAP = 2'd1,
    HOLD = 2'd2,
    JUMP = 2'd3
  } step_t;

  // Out-of-range samples are rejected before any other test, so an illegal
  // prev (left behind by a resync) can never produce STEP/WRAP/HOLD.
  function automatic step_t classify(input int unsigned prev,
                                     input int unsigned cur,
                                     input int unsigned modulus);
    step_t r;
    r = JUMP;
    if (cur >= modulus)                         r = JUMP;
    else if (prev < modulus - 1 && cur == prev + 1) r = STEP;
    else if (prev == modulus - 1 && cur == 0)   r = WRAP;
    else if (cur == prev)                       r = HOLD;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/count_monitor_if.sv
// +------------------------------------------------------------------+
// | count_monitor_if : count input, clear and status outputs         |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

interface count_monitor_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] count_in;
  logic             clr_wraps;
  logic             tick;
  logic [CNT_W-1:0] wraps;
  logic             stall;
  logic             glitch;

  modport master (output count_in, clr_wraps, input tick, wraps, stall, glitch);
  modport slave  (input count_in, clr_wraps, output tick, wraps, stall, glitch);
endinterface

`default_nettype wire

// File: rtl/count_monitor_stall_timer.sv
// +------------------------------------------------------------------+
// | count_monitor_stall_timer : saturating count of held samples     |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module count_monitor_stall_timer #(
  parameter int STALL_LIM = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic hold,
  output logic      expired
);
  localparam int             c_tw  = $clog2(STALL_LIM + 1);
  localparam logic [c_tw-1:0] c_lim = c_tw'(STALL_LIM);

  logic [c_tw-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst)                r_cnt <= '0;
    else if (!hold)          r_cnt <= '0;
    else if (r_cnt != c_lim) r_cnt <= r_cnt + 1'b1;
  end

  // Flags the hold edge that brings the count up to the limit, and every hold after it.
  assign expired = hold && (r_cnt >= c_lim - 1'b1);

endmodule

`default_nettype wire

// File: rtl/count_monitor.sv
// +------------------------------------------------------------------+
// | count_monitor : wrap/stall/glitch monitor for a modulo counter   |
// | Option macro COUNT_MONITOR_GLITCH_EN enables the glitch pulse    |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int CNT_W     = 8,
  parameter int STALL_LIM = 4
) (
  input wire logic       clk,
  input wire logic       rst,
  count_monitor_if.slave mon
);
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_prev;
  logic             r_tick;
  logic             r_stall;
  logic [CNT_W-1:0] r_wraps;
  step_t            w_class;
  logic             w_hold;
  logic             w_expired;

  assign w_class = classify(32'(r_prev), 32'(mon.count_in), MODULUS);
  assign w_hold  = (r_state != IDLE) && (w_class == HOLD);

  count_monitor_stall_timer #(.STALL_LIM(STALL_LIM)) u_stall_timer (
    .clk     (clk),
    .rst     (rst),
    .hold    (w_hold),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_prev  <= '0;
      r_tick  <= 1'b0;
      r_stall <= 1'b0;
      r_wraps <= '0;
    end else begin
      r_tick <= 1'b0;
      if (r_state == IDLE || w_class != HOLD) begin
        r_prev  <= mon.count_in;
        r_state <= TRACK;
        r_stall <= 1'b0;
      end else if (w_expired) begin
        r_state <= STALLED;
        r_stall <= 1'b1;
      end
      if (r_state != IDLE && w_class == WRAP) begin
        r_tick <= 1'b1;
        if (r_wraps != '1) r_wraps <= r_wraps + 1'b1;
      end
      // Clear is applied last so it overrides a same-edge increment.
      if (mon.clr_wraps) r_wraps <= '0;
    end
  end

  assign mon.tick  = r_tick;
  assign mon.stall = r_stall;
  assign mon.wraps = r_wraps;

`ifdef COUNT_MONITOR_GLITCH_EN
  logic r_glitch;
  always_ff @(posedge clk) begin
    if (!rst) r_glitch <= 1'b0;
    else      r_glitch <= (r_state != IDLE) && (w_class == JUMP);
  end
  assign mon.glitch = r_glitch;
`else
  assign mon.glitch = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_count_monitor.sv
// +------------------------------------------------------------------+
// | tb_count_monitor : directed vectors with a decoupled scoreboard  |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_count_monitor;
  localparam int WIDTH     = 4;
  localparam int MODULUS   = 16;
  localparam int CNT_W     = 2;
  localparam int STALL_LIM = 4;
`ifdef COUNT_MONITOR_GLITCH_EN
  localparam bit c_glitch_en = 1'b1;
`else
  localparam bit c_glitch_en = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  count_monitor_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) mon_if ();

  count_monitor #(
    .WIDTH(WIDTH), .MODULUS(MODULUS), .CNT_W(CNT_W), .STALL_LIM(STALL_LIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon_if)
  );

  typedef struct packed {
    logic [15:0]      id;
    logic             tick;
    logic [CNT_W-1:0] wraps;
    logic             stall;
    logic             glitch;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_id   = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected, input int id);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s vec=%0d actual=%0d expected=%0d", name, id, actual, expected);
    end
  endtask

  // Drive one sample and queue the outputs expected one edge later.
  task automatic vec(input logic r, input int c, input logic clr, input logic t,
                     input int w, input logic s, input logic j);
    exp_t e;
    @(negedge clk);
    rst              = r;
    mon_if.count_in  = WIDTH'(c);
    mon_if.clr_wraps = clr;
    e.id     = 16'(vec_id);
    e.tick   = t;
    e.wraps  = CNT_W'(w);
    e.stall  = s;
    e.glitch = j & c_glitch_en;
    sb.push_back(e);
    vec_id++;
  endtask

  task automatic ramp(input int from, input int to, input int w);
    for (int c = from; c <= to; c++) vec(1'b1, c, 1'b0, 1'b0, w, 1'b0, 1'b0);
  endtask

  exp_t m_e;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      check("tick",   32'(mon_if.tick),   32'(m_e.tick),   int'(m_e.id));
      check("wraps",  32'(mon_if.wraps),  32'(m_e.wraps),  int'(m_e.id));
      check("stall",  32'(mon_if.stall),  32'(m_e.stall),  int'(m_e.id));
      check("glitch", 32'(mon_if.glitch), 32'(m_e.glitch), int'(m_e.id));
    end
  end

  initial begin
    mon_if.count_in  = '0;
    mon_if.clr_wraps = 1'b0;

    // Reset state
    vec(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    vec(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Free-running 0..15, 40 samples: ticks after the two 15->0 steps
    for (int i = 0; i < 40; i++)
      vec(1'b1, i % 16, 1'b0, (i == 16 || i == 32), (i >= 32) ? 2 : (i >= 16) ? 1 : 0,
          1'b0, 1'b0);

    // Frozen at 7: stall after the 4th unchanged sample, clears after 8
    for (int h = 1; h <= 5; h++) vec(1'b1, 7, 1'b0, 1'b0, 2, (h >= 4), 1'b0);
    vec(1'b1, 8, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    vec(1'b1, 9, 1'b0, 1'b0, 2, 1'b0, 1'b0);

    // Jumps resync; the following sample is a normal step
    vec(1'b1, 2,  1'b0, 1'b0, 2, 1'b0, 1'b1);
    vec(1'b1, 3,  1'b0, 1'b0, 2, 1'b0, 1'b0);
    vec(1'b1, 9,  1'b0, 1'b0, 2, 1'b0, 1'b1);
    vec(1'b1, 10, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    ramp(11, 15, 2);

    // Stall at 15, then a wrap straight out of STALLED
    for (int h = 1; h <= 4; h++) vec(1'b1, 15, 1'b0, 1'b0, 2, (h == 4), 1'b0);
    vec(1'b1, 0, 1'b0, 1'b1, 3, 1'b0, 1'b0);

    // Saturation at 3, then clear coinciding with a wrap
    ramp(1, 15, 3);
    vec(1'b1, 0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    ramp(1, 15, 3);
    vec(1'b1, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    ramp(1, 15, 0);
    vec(1'b1, 0, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    ramp(1, 15, 1);

    // Reset at 15, release at 0: no tick; next wrap counts from zero
    vec(1'b0, 15, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    vec(1'b1, 0,  1'b0, 1'b0, 0, 1'b0, 1'b0);
    ramp(1, 15, 0);
    vec(1'b1, 0, 1'b0, 1'b1, 1, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #2;
    check("drain", 32'(sb.size()), 32'd0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 SHALL have parameter WIDTH, 4, bit width of the monitored count.
REQ-002 SHALL have parameter MODULUS, 16, count value at which the upstream counter wraps (sequence 0..MODULUS-1); 2 <= MODULUS <= 2**WIDTH.
REQ-003 SHALL have parameter CNT_W, 8, width of the wrap accumulator.
REQ-004 SHALL have parameter STALL_LIM, 4, consecutive unchanged samples that declare a stall; STALL_LIM >= 1.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port count_in  input  WIDTH  count value from the upstream modulo counter, sampled every clk.
REQ-008 SHALL have port clr_wraps  input  1  synchronous clear of the wraps accumulator.
REQ-009 SHALL have port tick  output  1  one-cycle pulse per detected wrap.
REQ-010 SHALL have port wraps  output  CNT_W  saturating count of wraps since reset or clear.
REQ-011 SHALL have port stall  output  1  high while the count is stalled.
REQ-012 SHALL have port glitch  output  1  one-cycle pulse on an illegal count step.

Function
REQ-013 SHALL hold prev (last sample) and an FSM with states IDLE, TRACK, STALLED.
REQ-014 IDLE: capture count_in into prev, clear stall timer, go to TRACK; no tick/glitch from IDLE.
REQ-015 In TRACK/STALLED, each edge classifies (prev, count_in): STEP if prev < MODULUS-1 and count_in == prev+1; WRAP if prev == MODULUS-1 and count_in == 0; HOLD if count_in == prev; JUMP otherwise.
REQ-016 STEP: prev <= count_in, stall timer cleared, state TRACK.
REQ-017 WRAP: as STEP; additionally tick high for exactly the next cycle; wraps increments, saturating at 2**CNT_W-1.
REQ-018 HOLD: stall timer increments (saturating at STALL_LIM); when it reaches STALL_LIM, state STALLED and stall high from the following cycle.
REQ-019 JUMP: prev <= count_in (resync), stall timer cleared, state TRACK; glitch behaviour per REQ-026/027.
REQ-020 STALLED: stall stays high while HOLD; first non-HOLD sample drops stall next cycle and is classified per REQ-015 (a WRAP out of STALLED SHALL tick).
REQ-021 All outputs registered; latency from count_in change to tick/glitch/stall update is one cycle.
REQ-022 clr_wraps together with WRAP: wraps <= 0 (clear wins), tick still pulses.
REQ-023 count_in >= MODULUS SHALL classify as JUMP.

Reset
REQ-024 rst low at a rising clk edge SHALL force state IDLE, prev 0, stall timer 0, tick 0, stall 0, glitch 0, wraps 0; priority over all other inputs.
REQ-025 Reset mid-operation SHALL discard history; the first sample after release is treated per REQ-014 with no tick/glitch.

Configuration
REQ-026 With COUNT_MONITOR_GLITCH_EN defined, JUMP SHALL assert glitch for exactly the next cycle.
REQ-027 Without COUNT_MONITOR_GLITCH_EN, glitch SHALL be tied 0 and JUMP SHALL resync silently; all other behaviour unchanged.

Structure
REQ-028 Package count_monitor_pkg SHALL hold the state enumeration (IDLE, TRACK, STALLED) and the step-class enumeration (STEP, WRAP, HOLD, JUMP).
REQ-029 Stall timer SHALL be a sub-module count_monitor_stall_timer (inputs clk, rst, hold, parameter STALL_LIM; output expired).

Verification
REQ-030 Upstream count 0..15 repeating, MODULUS 16, 40 cycles -> tick pulses once per 16 cycles, one cycle after count 15->0; wraps = 2; stall 0, glitch 0.
REQ-031 Count frozen at 7 for 6 cycles, STALL_LIM 4 -> stall high from the cycle after the 4th unchanged sample until one cycle after count moves to 8.
REQ-032 Count 3 then 9, GLITCH_EN defined -> glitch pulses one cycle, next sample 10 classified STEP; macro undefined -> glitch stays 0.
REQ-033 CNT_W 2, 5 wraps -> wraps reads 1,2,3,3,3; clr_wraps on a wrap edge -> wraps 0, tick 1.
REQ-034 rst low for one cycle while count = 15, released with count = 0 -> no tick, no glitch, wraps 0; next 15->0 ticks.
